stream_demux_1_4: RTL and testbench
===================================

Name: stream_demux_1_4

Overview:
- Registered 1-to-4 stream demultiplexer; it is the inverse of the team's 4:1 gate-level mux.
- A single upstream valid/ready stream carries a 2-bit destination select with each word. The block steers each word into one of four independent downstream valid/ready channels.
- Each channel owns a one-entry output register and an 8-bit delivered-word counter.
- Sits between a single producer and four consumers, e.g. fanning a data bus out to per-lane processing blocks.

Parameters:
- WIDTH, 4, data word width in bits.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- up_vld  input  1  upstream word valid
- up_rdy  output  1  block can accept upstream word this cycle
- up_sel  input  2  destination channel 0..3, qualified by up_vld
- up_data  input  WIDTH  upstream word
- down_vld  output  4  bit i: channel i register holds a word
- down_rdy  input  4  bit i: consumer i takes word this cycle
- down_data0..down_data3  output  WIDTH each  channel i register contents
- cnt0..cnt3  output  CNT_W each  words delivered on channel i (down_vld[i] & down_rdy[i])

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: down_vld = 4'b0000, down_data0..3 = 0, cnt0..3 = 0.
- Reset mid-operation: held words are discarded and counters cleared on the next edge.
- During the rst cycle up_rdy is don't-care, and no transfer is counted.
- Handshake rules:
  - Upstream transfer occurs when up_vld & up_rdy at a rising edge.
  - Downstream transfer on channel i occurs when down_vld[i] & down_rdy[i].
- Ready is combinational and depends only on the selected channel:
  - up_rdy = ~down_vld[up_sel] | down_rdy[up_sel].
  - A busy non-selected channel never stalls upstream.
  - up_rdy must not depend on up_vld.
- Per channel i, on a rising edge (rst = 0):
  - If an upstream transfer targets i: down_data_i <= up_data, down_vld[i] <= 1. This covers the simultaneous drain-and-refill case: no bubble, and the count still increments for the drained word.
  - Else if a downstream transfer occurs on i: down_vld[i] <= 0.
  - Otherwise the register holds; data is stable while down_vld[i] & ~down_rdy[i].
- Latency: a word accepted at edge N appears on down_vld/down_data of its channel after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained to any channel whose consumer holds down_rdy high.
- Only one channel can be loaded per cycle, but all four may drain in the same cycle.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Counters:
  - cnt_i increments by 1 on every downstream transfer on channel i.
  - Counters wrap modulo 2^CNT_W (255 -> 0 for CNT_W = 8) with no saturation or flag.
- up_sel and up_data are ignored when up_vld = 0.
- down_data_i is don't-care to consumers while down_vld[i] = 0. The implementation must still hold the last value.
- Selected-channel decode uses explicit per-channel enables, one-hot from up_sel. No priority between channels is needed, since exactly one is selected.

Test Plan:
- Reset, then idle with down_rdy = 4'hF -> down_vld = 0, cnt0..3 = 0, up_rdy = 1.
- Send 0x3 sel=0, 0x5 sel=1, 0xA sel=2, 0xC sel=3 back-to-back with down_rdy = 4'hF:
  - each word appears on its channel exactly 1 cycle after acceptance;
  - up_rdy stays 1 throughout;
  - afterwards cnt0..3 = 1 each.
- Backpressure with down_rdy = 0:
  - send 0x7 sel=2 -> down_vld = 4'b0100, down_data2 = 0x7;
  - next word sel=2 -> up_rdy = 0, down_data2 holds 0x7;
  - a word with sel=0 in the same period is accepted (up_rdy = 1).
- Drain-and-refill: channel 1 holds 0x9, down_rdy[1] = 1, upstream 0xE sel=1 in the same cycle:
  - up_rdy = 1;
  - next cycle down_vld[1] = 1, down_data1 = 0xE, cnt1 incremented by 1.
- Counter wrap: deliver 256 words on channel 3 -> cnt3 = 0, other counters unchanged.
- Assert rst while channels 0 and 2 hold words -> next cycle down_vld = 0 and all counts 0. Then a normal transfer works.

Source files
------------

// File: rtl/stream_demux_1_4_if.sv
// rtl/stream_demux_1_4_if.sv - upstream and four-lane downstream handshake bundle for stream_demux_1_4
interface stream_demux_1_4_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             up_vld;
  logic             up_rdy;
  logic [1:0]       up_sel;
  logic [WIDTH-1:0] up_data;
  logic [3:0]       down_vld;
  logic [3:0]       down_rdy;
  logic [WIDTH-1:0] down_data0;
  logic [WIDTH-1:0] down_data1;
  logic [WIDTH-1:0] down_data2;
  logic [WIDTH-1:0] down_data3;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;

  // Producer/consumer side: drives the upstream word and the downstream readies
  modport master (
    output up_vld, up_sel, up_data, down_rdy,
    input  up_rdy, down_vld, down_data0, down_data1, down_data2, down_data3,
           cnt0, cnt1, cnt2, cnt3
  );

  // Demultiplexer side
  modport slave (
    input  up_vld, up_sel, up_data, down_rdy,
    output up_rdy, down_vld, down_data0, down_data1, down_data2, down_data3,
           cnt0, cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// rtl/stream_demux_1_4.sv - registered 1-to-4 valid/ready stream demultiplexer with per-lane delivery counters
module stream_demux_1_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  stream_demux_1_4_if.slave bus
);

  logic [WIDTH-1:0] data_q [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [3:0]       vld_q;
  logic [3:0]       sel_en;
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             up_rdy;
  logic             up_xfer;

  // One-hot lane enable from the select; only one lane is ever addressed
  always_comb begin
    sel_en = 4'b0000;
    sel_en[bus.up_sel] = 1'b1;
  end

  // Ready looks only at the addressed lane so a stalled neighbour never blocks
  // traffic; a full lane still accepts when its consumer drains in the same cycle.
  assign up_rdy  = ~vld_q[bus.up_sel] | bus.down_rdy[bus.up_sel];
  assign up_xfer = bus.up_vld & up_rdy;
  assign load    = sel_en & {4{up_xfer}};
  assign drain   = vld_q & bus.down_rdy;

  // Lane registers: refill wins over drain so back-to-back words leave no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i] <= bus.up_data;
          vld_q[i]  <= 1'b1;
        end else if (drain[i]) begin
          vld_q[i]  <= 1'b0;
        end
        if (drain[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.up_rdy     = up_rdy;
  assign bus.down_vld   = vld_q;
  assign bus.down_data0 = data_q[0];
  assign bus.down_data1 = data_q[1];
  assign bus.down_data2 = data_q[2];
  assign bus.down_data3 = data_q[3];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
  assign bus.cnt2       = cnt_q[2];
  assign bus.cnt3       = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb/tb_stream_demux_1_4.sv - directed self-checking bench for stream_demux_1_4
module tb_stream_demux_1_4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  stream_demux_1_4_if #(.WIDTH(4), .CNT_W(8)) bus ();

  stream_demux_1_4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lane_data(input int i);
    case (i)
      0:       return bus.down_data0;
      1:       return bus.down_data1;
      2:       return bus.down_data2;
      default: return bus.down_data3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [3:0] data);
    bus.up_vld  = 1'b1;
    bus.up_sel  = sel;
    bus.up_data = data;
  endtask

  task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
    check({tag, "_cnt0"}, 32'(bus.cnt0), 32'(c0));
    check({tag, "_cnt1"}, 32'(bus.cnt1), 32'(c1));
    check({tag, "_cnt2"}, 32'(bus.cnt2), 32'(c2));
    check({tag, "_cnt3"}, 32'(bus.cnt3), 32'(c3));
  endtask

  logic [3:0] vals [4];

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.up_vld  = 1'b0;
    bus.up_sel  = 2'd0;
    bus.up_data = 4'h0;
    bus.down_rdy = 4'hF;
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'hA; vals[3] = 4'hC;

    // Reset and idle
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_down_vld", 32'(bus.down_vld), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_data%0d", i), 32'(lane_data(i)), 32'h0);
    check_counts("rst", 0, 0, 0, 0);
    check("idle_up_rdy", 32'(bus.up_rdy), 32'h1);
    step();
    check("idle_down_vld", 32'(bus.down_vld), 32'h0);

    // Back-to-back, one word per lane, all consumers ready
    for (int k = 0; k < 4; k++) begin
      send(2'(k), vals[k]);
      #1;
      check($sformatf("b2b_up_rdy%0d", k), 32'(bus.up_rdy), 32'h1);
      step();
      check($sformatf("b2b_vld%0d", k), 32'(bus.down_vld), 32'(4'b0001 << k));
      check($sformatf("b2b_data%0d", k), 32'(lane_data(k)), 32'(vals[k]));
    end
    bus.up_vld = 1'b0;
    step();
    check("b2b_drained", 32'(bus.down_vld), 32'h0);
    check_counts("b2b", 1, 1, 1, 1);

    // Backpressure on lane 2 must not stall lane 0
    bus.down_rdy = 4'h0;
    send(2'd2, 4'h7);
    #1;
    check("bp_first_rdy", 32'(bus.up_rdy), 32'h1);
    step();
    check("bp_vld", 32'(bus.down_vld), 32'h4);
    check("bp_data2", 32'(bus.down_data2), 32'h7);
    send(2'd2, 4'h8);
    #1;
    check("bp_stall_rdy", 32'(bus.up_rdy), 32'h0);
    step();
    check("bp_hold_data2", 32'(bus.down_data2), 32'h7);
    check("bp_hold_vld", 32'(bus.down_vld), 32'h4);
    send(2'd0, 4'h1);
    #1;
    check("bp_other_rdy", 32'(bus.up_rdy), 32'h1);
    step();
    check("bp_vld2", 32'(bus.down_vld), 32'h5);
    check("bp_data0", 32'(bus.down_data0), 32'h1);
    bus.up_vld   = 1'b0;
    bus.down_rdy = 4'hF;
    step();
    check("bp_drained", 32'(bus.down_vld), 32'h0);
    check_counts("bp", 2, 1, 2, 1);

    // Simultaneous drain and refill on lane 1
    bus.down_rdy = 4'h0;
    send(2'd1, 4'h9);
    step();
    check("dr_hold_vld", 32'(bus.down_vld), 32'h2);
    check("dr_hold_data1", 32'(bus.down_data1), 32'h9);
    bus.down_rdy = 4'b0010;
    send(2'd1, 4'hE);
    #1;
    check("dr_up_rdy", 32'(bus.up_rdy), 32'h1);
    step();
    check("dr_vld", 32'(bus.down_vld), 32'h2);
    check("dr_data1", 32'(bus.down_data1), 32'hE);
    check("dr_cnt1", 32'(bus.cnt1), 32'd2);
    bus.up_vld = 1'b0;
    step();
    check("dr_drained", 32'(bus.down_vld), 32'h0);
    check("dr_cnt1_final", 32'(bus.cnt1), 32'd3);
    bus.down_rdy = 4'hF;

    // Lane 3 counter wrap: starts at 1, 254 words bring it to 255, one more wraps to 0
    for (int i = 0; i < 254; i++) begin
      send(2'd3, 4'(i));
      step();
    end
    bus.up_vld = 1'b0;
    step();
    check("wrap_cnt3_255", 32'(bus.cnt3), 32'd255);
    check("wrap_hold_data3", 32'(bus.down_data3), 32'hD);
    check("wrap_idle_vld", 32'(bus.down_vld), 32'h0);
    send(2'd3, 4'h4);
    step();
    bus.up_vld = 1'b0;
    step();
    check_counts("wrap", 2, 3, 2, 0);

    // Reset while lanes 0 and 2 hold words, consumers ready during reset
    bus.down_rdy = 4'h0;
    send(2'd0, 4'h2);
    step();
    send(2'd2, 4'h6);
    step();
    bus.up_vld = 1'b0;
    check("mid_vld", 32'(bus.down_vld), 32'h5);
    bus.down_rdy = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", 32'(bus.down_vld), 32'h0);
    check_counts("mid_rst", 0, 0, 0, 0);
    bus.down_rdy = 4'h0;
    send(2'd1, 4'hB);
    step();
    bus.up_vld = 1'b0;
    check("post_vld", 32'(bus.down_vld), 32'h2);
    check("post_data1", 32'(bus.down_data1), 32'hB);
    bus.down_rdy = 4'hF;
    step();
    check("post_drained", 32'(bus.down_vld), 32'h0);
    check_counts("post", 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
